// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// State codes double as the LED phase encoding.
package alu_seq_pkg;

  localparam int OPERAND_W = 3;
  localparam int RESULT_W  = 4;
  localparam int SEL_W     = 2;
  localparam int PHASE_W   = 3;

  localparam logic [SEL_W-1:0] OP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] OP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] OP_SHIFT = 2'b10;
  localparam logic [SEL_W-1:0] OP_EQ    = 2'b11;

  typedef enum logic [PHASE_W-1:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_ISSUE   = 3'd3,
    S_CAPTURE = 3'd4,
    S_SHOW    = 3'd5
  } state_t;

  function automatic logic [PHASE_W-1:0] phase_code(input state_t s);
    return PHASE_W'(s);
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, optional debounce filter, registered rising-edge pulse.
// Debounce is compiled in with ALU_SEQ_DEBOUNCE_EN.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic fill1_r;
  logic fill2_r;
  logic armed_r;
  logic prev_r;
  logic pulse_r;
  logic lvl_s;

  // The armed flag stays low until a released level is seen after the synchronizer
  // has refilled, so a button held through reset cannot fire on release of reset.
  // Synchronizer, arming and edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      fill1_r <= 1'b0;
      fill2_r <= 1'b0;
      armed_r <= 1'b0;
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      fill1_r <= 1'b1;
      fill2_r <= fill1_r;
      if (fill2_r && !sync2_r) begin
        armed_r <= 1'b1;
      end
      prev_r  <= lvl_s;
      pulse_r <= lvl_s & ~prev_r & armed_r;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             acc_r;

  // Accepted level follows the synchronized level only after it has held for DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      acc_r <= 1'b0;
    end else if (sync2_r != acc_r) begin
      if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        acc_r <= sync2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign lvl_s = acc_r;
`else
  logic unused_cfg_s;

  assign unused_cfg_s = (DEBOUNCE_CYCLES > 0);
  assign lvl_s        = sync2_r;
`endif

  assign pulse = pulse_r;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and op select over three enter presses, issues them to the ALU, captures and holds the result.
// Optional button debounce via ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic [SEL_W-1:0]     swSelect,
  output logic                 op_valid,
  input  logic [RESULT_W-1:0]  alu_q,
  output logic [RESULT_W-1:0]  q,
  output logic                 q_valid,
  output logic [PHASE_W-1:0]   phase
);

  logic enter_pulse_s;
  logic clear_pulse_s;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_enter),
    .pulse (enter_pulse_s)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_clear),
    .pulse (clear_pulse_s)
  );

  state_t               state_r;
  state_t               state_next_s;
  logic                 load_a_s;
  logic                 load_b_s;
  logic                 load_op_s;
  logic                 capture_s;
  logic [OPERAND_W-1:0] a_r;
  logic [OPERAND_W-1:0] b_r;
  logic [SEL_W-1:0]     sel_r;
  logic [RESULT_W-1:0]  q_r;
  logic                 q_valid_r;
  logic                 op_valid_r;

  // Next-state and register-load decode; clear overrides any enter in the same cycle.
  always_comb begin
    state_next_s = state_r;
    load_a_s     = 1'b0;
    load_b_s     = 1'b0;
    load_op_s    = 1'b0;
    capture_s    = 1'b0;
    if (clear_pulse_s) begin
      state_next_s = S_LOAD_A;
    end else begin
      case (state_r)
        S_LOAD_A: begin
          if (enter_pulse_s) begin
            state_next_s = S_LOAD_B;
            load_a_s     = 1'b1;
          end else begin
            state_next_s = S_LOAD_A;
          end
        end
        S_LOAD_B: begin
          if (enter_pulse_s) begin
            state_next_s = S_LOAD_OP;
            load_b_s     = 1'b1;
          end else begin
            state_next_s = S_LOAD_B;
          end
        end
        S_LOAD_OP: begin
          if (enter_pulse_s) begin
            state_next_s = S_ISSUE;
            load_op_s    = 1'b1;
          end else begin
            state_next_s = S_LOAD_OP;
          end
        end
        S_ISSUE: begin
          state_next_s = S_CAPTURE;
        end
        S_CAPTURE: begin
          state_next_s = S_SHOW;
          capture_s    = 1'b1;
        end
        S_SHOW: begin
          if (enter_pulse_s) begin
            state_next_s = S_LOAD_A;
          end else begin
            state_next_s = S_SHOW;
          end
        end
        default: begin
          state_next_s = S_LOAD_A;
        end
      endcase
    end
  end

  // State register and operand/result registers; strobes are pre-decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst || clear_pulse_s) begin
      state_r    <= S_LOAD_A;
      a_r        <= '0;
      b_r        <= '0;
      sel_r      <= '0;
      q_r        <= '0;
      q_valid_r  <= 1'b0;
      op_valid_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      op_valid_r <= (state_next_s == S_ISSUE);
      q_valid_r  <= (state_next_s == S_SHOW);
      if (load_a_s) begin
        a_r <= sw;
      end
      if (load_b_s) begin
        b_r <= sw;
      end
      if (load_op_s) begin
        sel_r <= sw[SEL_W-1:0];
      end
      if (capture_s) begin
        q_r <= alu_q;
      end
    end
  end

  assign a        = a_r;
  assign b        = b_r;
  assign swSelect = sel_r;
  assign op_valid = op_valid_r;
  assign q        = q_r;
  assign q_valid  = q_valid_r;
  assign phase    = phase_code(state_r);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: table vectors, random operations against a
// reference model, and hand-written sequences for timing, clear, reset and ignored presses.
module tb_alu_operand_sequencer;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] swSelect;
  logic       op_valid;
  logic [3:0] alu_q;
  logic [3:0] q;
  logic       q_valid;
  logic [2:0] phase;
  bit         stub_mode;

  int vectors     = 0;
  int miscompares = 0;
  int ov_count    = 0;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .a         (a),
    .b         (b),
    .swSelect  (swSelect),
    .op_valid  (op_valid),
    .alu_q     (alu_q),
    .q         (q),
    .q_valid   (q_valid),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: add, subtract, shift left by b[1:0], equality; all results mod 16.
  function automatic logic [3:0] model_alu(input logic [2:0] x, input logic [2:0] y, input logic [1:0] s);
    int r;
    case (s)
      2'b00:   r = int'(x) + int'(y);
      2'b01:   r = int'(x) - int'(y);
      2'b10:   r = int'(x) << y[1:0];
      default: r = (x == y) ? 1 : 0;
    endcase
    return r[3:0];
  endfunction

  always_comb begin
    if (stub_mode) alu_q = (phase == 3'd4) ? 4'hA : 4'h3;
    else           alu_q = model_alu(a, b, swSelect);
  end

  always @(negedge clk) if (op_valid) ov_count++;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit ent, input bit clr);
    @(negedge clk);
    btn_enter = ent;
    btn_clear = clr;
    cyc(3 + LAT);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    cyc(5 + LAT);
  endtask

  task automatic run_op(input logic [2:0] va, input logic [2:0] vb, input logic [1:0] vs,
                        input logic top, input logic [3:0] exp_q, input string tag);
    if (phase == 3'd5) begin
      press(1'b1, 1'b0);
      check({tag, "_back_phase"}, phase, 0);
      check({tag, "_back_qv"}, q_valid, 0);
    end
    sw = va; press(1'b1, 1'b0);
    sw = vb; press(1'b1, 1'b0);
    sw = {top, vs};
    ov_count = 0;
    press(1'b1, 1'b0);
    check({tag, "_opv_count"}, ov_count, 1);
    check({tag, "_phase"}, phase, 5);
    check({tag, "_qv"}, q_valid, 1);
    check({tag, "_q"}, q, exp_q);
    check({tag, "_a"}, a, va);
    check({tag, "_b"}, b, vb);
    check({tag, "_sel"}, swSelect, vs);
  endtask

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] sel;
    logic [3:0] exp_q;
  } vec_t;

  vec_t tbl[6];
  bit   ov_seen[32];
  bit   qv_seen[32];

  initial begin
    tbl[0] = '{3'd3, 3'd2, 2'b00, 4'h5};
    tbl[1] = '{3'd5, 3'd6, 2'b01, 4'hF};
    tbl[2] = '{3'd4, 3'd1, 2'b10, 4'h8};
    tbl[3] = '{3'd7, 3'd7, 2'b11, 4'h1};
    tbl[4] = '{3'd6, 3'd5, 2'b11, 4'h0};
    tbl[5] = '{3'd7, 3'd7, 2'b00, 4'hE};

    stub_mode = 1'b0;
    sw = 3'd0; btn_enter = 1'b0; btn_clear = 1'b0; rst = 1'b1;
    cyc(3);
    check("rst_a", a, 0);
    check("rst_phase", phase, 0);
    check("rst_q", q, 0);
    check("rst_qv", q_valid, 0);
    check("rst_opv", op_valid, 0);
    rst = 1'b0;
    cyc(6);

    // Exact latency: LOAD_OP press observed cycle by cycle
    sw = 3'd3; press(1'b1, 1'b0);
    sw = 3'd2; press(1'b1, 1'b0);
    @(negedge clk);
    sw = 3'd0;
    btn_enter = 1'b1;
    for (int i = 1; i <= 10 + LAT; i++) begin
      @(negedge clk);
      ov_seen[i - LAT] = op_valid;
      qv_seen[i - LAT] = q_valid;
      if (i == 3 + LAT) btn_enter = 1'b0;
    end
    check("lat_opv_n3", ov_seen[3], 0);
    check("lat_opv_n4", ov_seen[4], 1);
    check("lat_opv_n5", ov_seen[5], 0);
    check("lat_qv_n5", qv_seen[5], 0);
    check("lat_qv_n6", qv_seen[6], 1);
    check("lat_q_add", q, 5);
    cyc(5 + LAT);

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].sel, i[0], tbl[i].exp_q, $sformatf("tbl%0d", i));

    for (int i = 0; i < 12; i++) begin
      logic [2:0] ra, rb;
      logic [1:0] rs;
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      rs = 2'($urandom_range(0, 3));
      run_op(ra, rb, rs, 1'($urandom_range(0, 1)), model_alu(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    // Capture timing with a stubbed ALU
    stub_mode = 1'b1;
    run_op(3'd1, 3'd1, 2'b00, 1'b0, 4'hA, "stub");
    cyc(5);
    check("stub_q_hold", q, 10);
    stub_mode = 1'b0;

    // Mid-sequence clear
    press(1'b1, 1'b0);
    sw = 3'd7; press(1'b1, 1'b0);
    check("clr_pre_phase", phase, 1);
    check("clr_pre_a", a, 7);
    ov_count = 0;
    press(1'b0, 1'b1);
    check("clr_phase", phase, 0);
    check("clr_a", a, 0);
    check("clr_sel", swSelect, 0);
    check("clr_no_opv", ov_count, 0);

`ifndef ALU_SEQ_DEBOUNCE_EN
    // Second enter pulse lands in CAPTURE and must be ignored
    sw = 3'd2; press(1'b1, 1'b0);
    sw = 3'd3; press(1'b1, 1'b0);
    sw = 3'd0;
    ov_count = 0;
    @(negedge clk); btn_enter = 1'b1;
    @(negedge clk); btn_enter = 1'b0;
    @(negedge clk); btn_enter = 1'b1;
    @(negedge clk); btn_enter = 1'b0;
    cyc(10);
    check("ign_phase", phase, 5);
    check("ign_qv", q_valid, 1);
    check("ign_opv", ov_count, 1);
    check("ign_q", q, 5);
`else
    sw = 3'd2; press(1'b1, 1'b0);
    sw = 3'd3; press(1'b1, 1'b0);
    sw = 3'd0; press(1'b1, 1'b0);
    check("pre_sim_phase", phase, 5);
`endif

    // Simultaneous enter and clear in SHOW
    press(1'b1, 1'b1);
    check("sim_phase", phase, 0);
    check("sim_qv", q_valid, 0);
    check("sim_q", q, 0);

    // Reset in CAPTURE with enter held
    sw = 3'd1; press(1'b1, 1'b0);
    sw = 3'd1; press(1'b1, 1'b0);
    @(negedge clk);
    btn_enter = 1'b1;
    begin
      int guard = 0;
      while (phase != 3'd4 && guard < 60 + LAT) begin
        @(negedge clk);
        guard++;
      end
      check("rst_reach_capture", phase, 4);
    end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10 + LAT);
    check("rstc_phase", phase, 0);
    check("rstc_a", a, 0);
    check("rstc_b", b, 0);
    check("rstc_sel", swSelect, 0);
    check("rstc_q", q, 0);
    check("rstc_qv", q_valid, 0);
    check("rstc_opv", op_valid, 0);
    btn_enter = 1'b0;
    cyc(8 + LAT);
    check("rstc_release_phase", phase, 0);
    press(1'b1, 1'b0);
    check("rstc_repress_phase", phase, 1);
    press(1'b0, 1'b1);
    check("rstc_clear_phase", phase, 0);

`ifdef ALU_SEQ_DEBOUNCE_EN
    @(negedge clk); btn_enter = 1'b1;
    cyc(10); btn_enter = 1'b0;
    cyc(40);
    check("db_glitch_phase", phase, 0);
    @(negedge clk); btn_enter = 1'b1;
    cyc(20); btn_enter = 1'b0;
    cyc(40);
    check("db_press_phase", phase, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end controller that drives the 3-bit ALU from board switches and a single enter button. It collects operand A, operand B and the 2-bit operation select over three button presses. It then presents them to the ALU, captures the 4-bit ALU result one settle cycle later, and holds it for display. It sits between the board I/O (switches, buttons, LEDs) and the combinational ALU, and acts as the initiator of the ALU's operand/select interface.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before a button level is accepted; used only when debounce is compiled in
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw  in  3  switch value; sw[2:0] is loaded as an operand, sw[1:0] is loaded as the op select
- btn_enter  in  1  raw enter button, asynchronous to clk
- btn_clear  in  1  raw abort button, asynchronous to clk
- a  out  3  operand A to the ALU (registered)
- b  out  3  operand B to the ALU (registered)
- swSelect  out  2  ALU operation select (registered): 00 add, 01 subtract, 10 shift, 11 equality
- op_valid  out  1  one-cycle strobe; operands and select are stable and being evaluated
- alu_q  in  4  ALU result
- q  out  4  captured result
- q_valid  out  1  q holds a result for the current operand set
- phase  out  3  current state code, for the LEDs

## Operation
- Button path:
  - Each button passes through a 2-flop synchronizer, then edge detection.
  - A rising edge produces a one-cycle enter_pulse or clear_pulse.
- States and transitions:
  - LOAD_A: on enter_pulse, a <= sw, go to LOAD_B.
  - LOAD_B: on enter_pulse, b <= sw, go to LOAD_OP.
  - LOAD_OP: on enter_pulse, swSelect <= sw[1:0], go to ISSUE.
  - ISSUE: op_valid = 1 for this cycle only; unconditionally go to CAPTURE.
  - CAPTURE: q <= alu_q at the end of this cycle; go to SHOW.
  - SHOW: q_valid = 1. On enter_pulse, clear q_valid and go to LOAD_A. a, b and swSelect keep their values until overwritten.
- Abort and ignored inputs:
  - clear_pulse in any state: a, b, swSelect, q and q_valid are zeroed and the state goes to LOAD_A next cycle.
  - enter_pulse in ISSUE or CAPTURE is ignored and not queued.
  - Simultaneous enter_pulse and clear_pulse: clear wins.
- Width rules:
  - sw[2] is ignored when loading the op select.
  - No arithmetic is performed here. q is alu_q verbatim, 4 bits, no sign interpretation.

## Timing
- Reset values: a=0, b=0, swSelect=0, op_valid=0, q=0, q_valid=0. State = LOAD_A, phase=0. Synchronizers, edge-detect flops and debounce counters are also cleared.
- Reset mid-operation (any state) behaves like clear but also clears the button pipeline. A button held across reset release generates no pulse until it is released and pressed again.
- Button latency: a raw edge produces a pulse 3 cycles later without debounce, or 3+DEBOUNCE_CYCLES cycles later with debounce.
- Operation latency: enter_pulse in LOAD_OP at cycle N gives ISSUE at N+1 (op_valid=1), CAPTURE at N+2, and q/q_valid valid at N+3.
- a, b and swSelect change only on the clock edge that consumes an enter_pulse. They are constant from ISSUE through SHOW, so the ALU has at least one full cycle to settle before capture.
- phase encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, ISSUE=3, CAPTURE=4, SHOW=5.

## Configuration
- ALU_SEQ_DEBOUNCE_EN defined:
  - The synchronized level of each button must hold for DEBOUNCE_CYCLES consecutive cycles before the accepted level changes.
  - Edge detection runs on the accepted level.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- ALU_SEQ_DEBOUNCE_EN undefined:
  - Edge detection runs directly on the synchronized level.
  - DEBOUNCE_CYCLES is unused.
  - Every synchronized rising edge produces a pulse.

## Structure
- Shared package alu_seq_pkg holds:
  - the state typedef and phase encodings;
  - op select constants OP_ADD=2'b00, OP_SUB=2'b01, OP_SHIFT=2'b10, OP_EQ=2'b11;
  - widths OPERAND_W=3 and RESULT_W=4.
- One sub-module, btn_conditioner: synchronizer, optional debounce counter and rising-edge detector, instantiated once per button.
- The state machine and operand/result registers live in the top module.

## Test plan
- Add path: connect the real ALU, enter a=3, b=2, select 00. Expect op_valid for exactly 1 cycle, then q=4'b0101 and q_valid=1 three cycles after the LOAD_OP pulse.
- Capture timing: stub alu_q=4'hA during CAPTURE and 4'h3 otherwise. Expect q=4'hA, and q stays 4'hA after alu_q returns to 4'h3.
- Mid-sequence clear: load a=7, press clear while in LOAD_B. Expect phase=0 and a=0 next cycle, with no op_valid ever asserted.
- Ignored presses and priority:
  - enter pulses during ISSUE/CAPTURE leave the state flow unchanged;
  - simultaneous enter and clear in SHOW leave q_valid=0 and phase=0.
- Reset: assert rst in CAPTURE with btn_enter held high. Expect all outputs at reset values, and no pulse until the button is released and pressed again.
- Debounce (with ALU_SEQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=16):
  - a 10-cycle glitch on btn_enter produces no phase change;
  - a 20-cycle press advances phase from 0 to 1 exactly once.
